apb_req_demux: RTL

//  APB request fan-out between the MDIO engine's req_* master port and NSLV register slaves (top_regfile + analog/capture banks).

---
 rtl/apb_req_demux_pkg.sv | 24 ++
 rtl/apb_demux_timer.sv | 49 ++++
 rtl/apb_req_demux.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_demux_pkg.sv
// ---------------------------------------------------------------------------
// apb_req_demux_pkg
// Shared definitions for the APB request demultiplexer: FSM state encodings,
// the page field position inside the upstream address, the pattern returned
// when a slave hangs past the access-phase limit, and a saturating increment.
// ---------------------------------------------------------------------------
package apb_req_demux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } demux_state_e;

   localparam int          PAGE_MSB        = 20;
   localparam int          PAGE_LSB        = 16;
   localparam logic [15:0] TIMEOUT_PATTERN = 16'hDEAD;

   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      return (val == 8'hFF) ? val : val + 8'd1;
   endfunction

endpackage

// File: rtl/apb_demux_timer.sv
// ---------------------------------------------------------------------------
// apb_demux_timer
// ACCESS-phase watchdog. Down-counter loaded with (limit - 1) while the
// demux is in SETUP, decremented each ACCESS cycle, and flagging expiry at
// terminal count zero. It exists only when APB_DEMUX_TIMEOUT_EN is defined.
// Ports:
//   clk_200m   in   block clock
//   rstn_200m  in   asynchronous active-low reset
//   load       in   load load_val into the counter
//   load_val   in   W  value loaded (limit - 1)
//   count_en   in   decrement while nonzero
//   expire     out  counter at terminal count
// ---------------------------------------------------------------------------
`ifdef APB_DEMUX_TIMEOUT_EN
module apb_demux_timer #(
   parameter int W = 16
) (
   input  logic         clk_200m,
   input  logic         rstn_200m,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         count_en,
   output logic         expire
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (count_en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_200m or negedge rstn_200m) begin
      if (!rstn_200m) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == '0);

endmodule
`endif

// File: rtl/apb_req_demux.sv
// ---------------------------------------------------------------------------
// apb_req_demux
// Fans the MDIO engine's APB request port out to NSLV register slaves.
// req_paddr[20:16] selects the slave; each transfer is re-issued downstream
// as a clean SETUP/ACCESS pair. Out-of-range pages complete immediately with
// an error. All outputs are registered.
//
// Optional feature macro: APB_DEMUX_TIMEOUT_EN
//   defined     : a slave that stays unready for TIMEOUT_CYC ACCESS cycles is
//                 abandoned and the transfer completes with pslverr=1,
//                 prdata=16'hDEAD.
//   not defined : ACCESS waits indefinitely for the selected slave.
//
// Ports:
//   clk_200m, rstn_200m          clock, async active-low reset
//   req_psel/penable/pwrite      upstream APB control
//   req_paddr[20:0]              [20:16] page, [15:0] slave offset
//   req_pwdata[15:0]             upstream write data
//   req_pready/prdata/pslverr    one-cycle completion strobe + response
//   slv_psel[NSLV]               one-hot downstream select
//   slv_penable/pwrite/paddr/pwdata  downstream APB drive
//   slv_pready/prdata/pslverr    per-slave response, slave i data at [16*i+:16]
//   err_cnt[7:0]                 saturating count of strobed error completions
//
// state  | meaning
// IDLE   | waiting for upstream setup phase; decode page
// SETUP  | downstream setup phase, selected psel high, penable low
// ACCESS | downstream access phase, waiting for selected slave ready
// DONE   | one cycle; upstream strobe (if any) is visible on the outputs
// ---------------------------------------------------------------------------
module apb_req_demux
   import apb_req_demux_pkg::*;
#(
   parameter int NSLV        = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clk_200m,
   input  logic               rstn_200m,
   input  logic               req_psel,
   input  logic               req_penable,
   input  logic               req_pwrite,
   input  logic [20:0]        req_paddr,
   input  logic [15:0]        req_pwdata,
   output logic               req_pready,
   output logic [15:0]        req_prdata,
   output logic               req_pslverr,
   output logic [NSLV-1:0]    slv_psel,
   output logic               slv_penable,
   output logic               slv_pwrite,
   output logic [15:0]        slv_paddr,
   output logic [15:0]        slv_pwdata,
   input  logic [NSLV-1:0]    slv_pready,
   input  logic [NSLV*16-1:0] slv_prdata,
   input  logic [NSLV-1:0]    slv_pslverr,
   output logic [7:0]         err_cnt
);

   localparam logic [5:0] NSLV_W = 6'(NSLV);

   demux_state_e      state_q,       state_d;
   logic              pwrite_q,      pwrite_d;
   logic [15:0]       paddr_q,       paddr_d;
   logic [15:0]       pwdata_q,      pwdata_d;
   logic [4:0]        page_q,        page_d;
   logic [NSLV-1:0]   slv_psel_q,    slv_psel_d;
   logic              slv_penable_q, slv_penable_d;
   logic              req_pready_q,  req_pready_d;
   logic [15:0]       req_prdata_q,  req_prdata_d;
   logic              req_pslverr_q, req_pslverr_d;
   logic [7:0]        err_cnt_q,     err_cnt_d;

   logic [4:0]        page_w;
   logic              page_valid_w;
   logic              sel_pready;
   logic [15:0]       sel_prdata;
   logic              sel_pslverr;
   logic              tmr_expire;

   assign page_w       = req_paddr[PAGE_MSB:PAGE_LSB];
   assign page_valid_w = ({1'b0, page_w} < NSLV_W);

   // Only the latched page's response is looked at; everyone else is ignored.
   always_comb begin
      sel_pready  = 1'b0;
      sel_prdata  = '0;
      sel_pslverr = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (page_q == 5'(i)) begin
            sel_pready  = slv_pready[i];
            sel_prdata  = slv_prdata[16*i +: 16];
            sel_pslverr = slv_pslverr[i];
         end
      end
   end

`ifdef APB_DEMUX_TIMEOUT_EN
   localparam int               TMR_W    = 16;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

   logic tmr_load;
   logic tmr_count_en;

   assign tmr_load     = (state_q == ST_SETUP);
   assign tmr_count_en = (state_q == ST_ACCESS);

   apb_demux_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk_200m  (clk_200m),
      .rstn_200m (rstn_200m),
      .load      (tmr_load),
      .load_val  (TMR_LOAD),
      .count_en  (tmr_count_en),
      .expire    (tmr_expire)
   );
`else
   logic [31:0] unused_timeout_cyc;
   assign unused_timeout_cyc = TIMEOUT_CYC;
   assign tmr_expire         = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      page_d        = page_q;
      slv_psel_d    = slv_psel_q;
      slv_penable_d = slv_penable_q;
      req_pready_d  = 1'b0;
      req_prdata_d  = '0;
      req_pslverr_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_psel && !req_penable) begin
               pwrite_d = req_pwrite;
               paddr_d  = req_paddr[15:0];
               pwdata_d = req_pwdata;
               page_d   = page_w;
               if (page_valid_w) begin
                  for (int i = 0; i < NSLV; i++) begin
                     slv_psel_d[i] = (page_w == 5'(i));
                  end
                  state_d = ST_SETUP;
               end else begin
                  // Upstream is guaranteed to be in its access phase next
                  // cycle, so the error strobe is issued unconditionally.
                  req_pready_d  = 1'b1;
                  req_pslverr_d = 1'b1;
                  state_d       = ST_DONE;
               end
            end
         end

         ST_SETUP: begin
            slv_penable_d = 1'b1;
            state_d       = ST_ACCESS;
         end

         ST_ACCESS: begin
            // The strobe decision is registered on entry to DONE so that
            // req_pready is visible during the DONE cycle itself; an upstream
            // that has already left its access phase gets nothing.
            if (sel_pready || tmr_expire) begin
               slv_psel_d    = '0;
               slv_penable_d = 1'b0;
               state_d       = ST_DONE;
               if (req_psel && req_penable) begin
                  req_pready_d = 1'b1;
                  if (sel_pready) begin
                     req_prdata_d  = pwrite_q ? 16'h0000 : sel_prdata;
                     req_pslverr_d = sel_pslverr;
                  end else begin
                     req_prdata_d  = TIMEOUT_PATTERN;
                     req_pslverr_d = 1'b1;
                  end
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      err_cnt_d = (req_pready_d && req_pslverr_d) ? sat_inc8(err_cnt_q) : err_cnt_q;
   end

   always_ff @(posedge clk_200m or negedge rstn_200m) begin
      if (!rstn_200m) begin
         state_q       <= ST_IDLE;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         page_q        <= '0;
         slv_psel_q    <= '0;
         slv_penable_q <= 1'b0;
         req_pready_q  <= 1'b0;
         req_prdata_q  <= '0;
         req_pslverr_q <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         page_q        <= page_d;
         slv_psel_q    <= slv_psel_d;
         slv_penable_q <= slv_penable_d;
         req_pready_q  <= req_pready_d;
         req_prdata_q  <= req_prdata_d;
         req_pslverr_q <= req_pslverr_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign req_pready  = req_pready_q;
   assign req_prdata  = req_prdata_q;
   assign req_pslverr = req_pslverr_q;
   assign slv_psel    = slv_psel_q;
   assign slv_penable = slv_penable_q;
   assign slv_pwrite  = pwrite_q;
   assign slv_paddr   = paddr_q;
   assign slv_pwdata  = pwdata_q;
   assign err_cnt     = err_cnt_q;

endmodule
